// File: rtl/dkong_obj_dma.sv
// Sprite-list DMA: copies LEN bytes from CPU work RAM into object RAM while
// holding the CPU bus. Three enable ticks per byte (read, latch, write), with
// a freeze-and-resume path when the CPU withdraws its bus acknowledge.
module dkong_obj_dma #(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter logic [9:0]  DST_BASE = 10'h000,
    parameter int unsigned LEN      = 384
) (
    input  logic        CLK_24M,
    input  logic        I_RST,
    input  logic        CLK_12M_EN,
    input  logic        I_DMA_START,
    input  logic        I_BUSAKn,
    output logic        O_BUSRQn,
    output logic [15:0] O_SRC_AB,
    output logic        O_SRC_RDn,
    input  logic [7:0]  I_SRC_DB,
    output logic [9:0]  O_OBJ_AB,
    output logic [7:0]  O_OBJ_DB,
    output logic        O_OBJ_WRn,
    output logic        O_BUSY,
    output logic        O_DONE
);

    localparam logic [9:0] LastIdx = 10'(LEN - 1);

    typedef enum logic [2:0] {StIdle, StReq, StRd, StLat, StWr, StDone} state_e;

    state_e      state_q;
    logic [9:0]  count_q;
    logic        start_prev_q;
    logic        pending_q;
    logic        hold_q;      // transfer frozen by a lost bus grant
    logic        busrqn_q;
    logic [15:0] src_ab_q;
    logic        src_rdn_q;
    logic [9:0]  obj_ab_q;
    logic [7:0]  obj_db_q;
    logic        obj_wrn_q;
    logic        busy_q;
    logic        done_q;
    logic        start_edge;
    logic        in_xfer;

    assign start_edge = I_DMA_START & ~start_prev_q;
    assign in_xfer    = (state_q == StRd) || (state_q == StLat) || (state_q == StWr);

    // Transfer FSM; every output is registered and set on entry to the state it belongs to.
    always_ff @(posedge CLK_24M) begin
        if (I_RST) begin
            state_q      <= StIdle;
            count_q      <= '0;
            start_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            hold_q       <= 1'b0;
            busrqn_q     <= 1'b1;
            src_ab_q     <= SRC_BASE;
            src_rdn_q    <= 1'b1;
            obj_ab_q     <= DST_BASE;
            obj_db_q     <= '0;
            obj_wrn_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (CLK_12M_EN) begin
            start_prev_q <= I_DMA_START;
            done_q       <= 1'b0;
            // One-deep request queue; the DONE arm below consumes it.
            if (start_edge && (state_q == StReq || in_xfer)) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q  <= StReq;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        busrqn_q <= 1'b0;
                    end
                end
                StReq: begin
                    if (!I_BUSAKn) begin
                        state_q   <= StRd;
                        src_ab_q  <= SRC_BASE + {6'd0, count_q};
                        src_rdn_q <= 1'b0;
                    end
                end
                StRd, StLat, StWr: begin
                    if (I_BUSAKn) begin
                        hold_q    <= 1'b1;
                        src_rdn_q <= 1'b1;
                        obj_wrn_q <= 1'b1;
                    end else if (hold_q) begin
                        // Grant back: replay the frozen state's strobe for one tick.
                        hold_q    <= 1'b0;
                        src_rdn_q <= (state_q != StRd);
                        obj_wrn_q <= (state_q != StWr);
                    end else if (state_q == StRd) begin
                        state_q   <= StLat;
                        src_rdn_q <= 1'b1;
                    end else if (state_q == StLat) begin
                        state_q   <= StWr;
                        obj_db_q  <= I_SRC_DB;
                        obj_ab_q  <= DST_BASE + count_q;
                        obj_wrn_q <= 1'b0;
                    end else begin
                        obj_wrn_q <= 1'b1;
                        count_q   <= count_q + 10'd1;
                        if (count_q == LastIdx) begin
                            state_q  <= StDone;
                            busrqn_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state_q   <= StRd;
                            src_ab_q  <= SRC_BASE + {6'd0, count_q + 10'd1};
                            src_rdn_q <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (pending_q || start_edge) begin
                        pending_q <= 1'b0;
                        state_q   <= StReq;
                        count_q   <= '0;
                        busrqn_q  <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_BUSRQn  = busrqn_q;
    assign O_SRC_AB  = src_ab_q;
    assign O_SRC_RDn = src_rdn_q;
    assign O_OBJ_AB  = obj_ab_q;
    assign O_OBJ_DB  = obj_db_q;
    assign O_OBJ_WRn = obj_wrn_q;
    assign O_BUSY    = busy_q;
    assign O_DONE    = done_q;

endmodule
